// File: rtl/gb_obj_pkg.sv
// Shared types and constants for the PPU object scan/fetch path.
package gb_obj_pkg;

    localparam logic [1:0] OAM_Y    = 2'd0;
    localparam logic [1:0] OAM_X    = 2'd1;
    localparam logic [1:0] OAM_TILE = 2'd2;
    localparam logic [1:0] OAM_ATTR = 2'd3;

    typedef logic [1:0] scan_state_t;
    localparam scan_state_t S_IDLE = 2'd0;
    localparam scan_state_t S_Y    = 2'd1;
    localparam scan_state_t S_X    = 2'd2;
    localparam scan_state_t S_DONE = 2'd3;

    typedef logic [1:0] fetch_state_t;
    localparam fetch_state_t F_IDLE = 2'd0;
    localparam fetch_state_t F_TILE = 2'd1;
    localparam fetch_state_t F_ATTR = 2'd2;
    localparam fetch_state_t F_REQ  = 2'd3;

    typedef struct packed {
        logic       valid;
        logic [5:0] idx;
        logic [7:0] x;
        logic [3:0] row;
    } obj_slot_t;

    function automatic logic [7:0] oam_addr(input logic [5:0] idx, input logic [1:0] off);
        return {idx, off};
    endfunction

endpackage

// File: rtl/oam_obj_scanner_select.sv
// Priority encoder: lowest valid slot whose X matches the fetcher X.
module obj_slot_select
    import gb_obj_pkg::*;
#(
    parameter int unsigned SLOTS = 10
) (
    input  obj_slot_t  slots [SLOTS],
    input  logic [7:0] h_cnt,
    output logic       any,
    output logic [3:0] slot
);

    always_comb begin
        any  = 1'b0;
        slot = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (!any && slots[i].valid && slots[i].x == h_cnt) begin
                any  = 1'b1;
                slot = 4'(i);
            end
        end
    end

endmodule

// File: rtl/oam_obj_scanner.sv
// Per-line OAM scan into object slots, then X-ordered tile/attr hand-off to the fetcher.
module oam_obj_scanner
    import gb_obj_pkg::*;
#(
    parameter int OBJ_COUNT    = 40,
    parameter int MAX_PER_LINE = 10,
    parameter int IDX_W        = 6
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        lcd_on,
    input  logic        size16,
    input  logic        obj_en,
    input  logic        is_gbc,
    input  logic [7:0]  v_cnt,
    input  logic [7:0]  h_cnt,
    input  logic        scan_start,
    input  logic        fetch_win,
    output logic [7:0]  oam_rd_addr,
    input  logic [7:0]  oam_rd_data,
    output logic        oam_bus_req,
    output logic        fetch_req,
    input  logic        fetch_ack,
    output logic [10:0] obj_tile_addr,
    output logic [7:0]  obj_attr,
    output logic [3:0]  obj_slot,
    output logic        scan_done,
    output logic        obj_overflow,
    output logic [4:0]  obj_hits
);

    scan_state_t      scan_st;
    fetch_state_t     fetch_st;
    logic [IDX_W-1:0] idx;
    logic [5:0]       y_idx;
    logic [7:0]       y_lat;
    logic             pend;
    obj_slot_t        slots [MAX_PER_LINE];
    logic [4:0]       hits;
    logic             overflow, done_r, first_line;
    logic [3:0]       fslot, frow;
    logic [5:0]       fidx;
    logic [7:0]       tile, attr;
    logic             req;

    logic             sel_any;
    logic [3:0]       sel;
    logic [5:0]       sel_idx;
    logic [3:0]       sel_row;
    logic [8:0]       v9, y9, y_end;
    logic [3:0]       row_n;
    logic             hit, scan_busy, fetch_go;

    // pend marks the cycle after S_X, when oam_rd_data carries the X byte
    assign v9    = {1'b0, v_cnt} + 9'd16;
    assign y9    = {1'b0, y_lat};
    assign y_end = y9 + (size16 ? 9'd16 : 9'd8);
    assign hit   = pend && (v9 >= y9) && (v9 < y_end);
    assign row_n = 4'(v9 - y9);

    obj_slot_select #(.SLOTS(MAX_PER_LINE)) u_select (
        .slots (slots),
        .h_cnt (h_cnt),
        .any   (sel_any),
        .slot  (sel)
    );

    always_comb begin
        sel_idx = '0;
        sel_row = '0;
        for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
            if (4'(i) == sel) begin
                sel_idx = slots[i].idx;
                sel_row = slots[i].row;
            end
        end
    end

    assign scan_busy = (scan_st == S_Y) || (scan_st == S_X) || pend;
    assign fetch_go  = lcd_on && fetch_win && (obj_en || is_gbc) && sel_any
                       && !scan_busy && (fetch_st == F_IDLE);

    // The tile address goes out on the match cycle so the tile byte arrives in F_TILE
    always_comb begin
        oam_rd_addr = '0;
        oam_bus_req = 1'b0;
        if (scan_st == S_Y) begin
            oam_rd_addr = oam_addr(6'(idx), OAM_Y);
            oam_bus_req = 1'b1;
        end else if (scan_st == S_X) begin
            oam_rd_addr = oam_addr(6'(idx), OAM_X);
            oam_bus_req = 1'b1;
        end else if (fetch_go) begin
            oam_rd_addr = oam_addr(sel_idx, OAM_TILE);
            oam_bus_req = 1'b1;
        end else if (fetch_st == F_TILE) begin
            oam_rd_addr = oam_addr(fidx, OAM_ATTR);
            oam_bus_req = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scan_st    <= S_IDLE;
            fetch_st   <= F_IDLE;
            idx        <= '0;
            y_idx      <= '0;
            y_lat      <= '0;
            pend       <= 1'b0;
            slots      <= '{default: '0};
            hits       <= '0;
            overflow   <= 1'b0;
            done_r     <= 1'b0;
            first_line <= 1'b0;
            fslot      <= '0;
            frow       <= '0;
            fidx       <= '0;
            tile       <= '0;
            attr       <= '0;
            req        <= 1'b0;
        end else if (ce) begin
            if (!lcd_on) begin
                scan_st    <= S_IDLE;
                fetch_st   <= F_IDLE;
                idx        <= '0;
                pend       <= 1'b0;
                slots      <= '{default: '0};
                hits       <= '0;
                overflow   <= 1'b0;
                done_r     <= 1'b0;
                first_line <= 1'b1;
                fslot      <= '0;
                frow       <= '0;
                tile       <= '0;
                attr       <= '0;
                req        <= 1'b0;
            end else if (scan_start) begin
                slots      <= '{default: '0};
                hits       <= '0;
                overflow   <= 1'b0;
                done_r     <= 1'b0;
                pend       <= 1'b0;
                idx        <= '0;
                fetch_st   <= F_IDLE;
                req        <= 1'b0;
                first_line <= 1'b0;
                scan_st    <= first_line ? S_IDLE : S_Y;
            end else begin
                pend <= 1'b0;
                case (scan_st)
                    S_Y: scan_st <= S_X;
                    S_X: begin
                        y_lat <= oam_rd_data;
                        y_idx <= 6'(idx);
                        pend  <= 1'b1;
                        if (idx == IDX_W'(OBJ_COUNT - 1)) begin
                            scan_st <= S_DONE;
                        end else begin
                            idx     <= idx + 1'b1;
                            scan_st <= S_Y;
                        end
                    end
                    default: ;
                endcase

                if (pend && scan_st == S_DONE)
                    done_r <= 1'b1;
                if (hit) begin
                    if ({27'd0, hits} < 32'(MAX_PER_LINE)) begin
                        for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
                            if (5'(i) == hits)
                                slots[i] <= '{valid: 1'b1, idx: y_idx, x: oam_rd_data, row: row_n};
                        end
                        hits <= hits + 5'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end

                case (fetch_st)
                    F_IDLE: begin
                        if (fetch_go) begin
                            fslot    <= sel;
                            fidx     <= sel_idx;
                            frow     <= sel_row;
                            fetch_st <= F_TILE;
                        end
                    end
                    F_TILE: begin
                        tile     <= oam_rd_data;
                        fetch_st <= F_ATTR;
                    end
                    F_ATTR: begin
                        attr     <= oam_rd_data;
                        if (oam_rd_data[6])
                            frow <= ~frow;
                        req      <= 1'b1;
                        fetch_st <= F_REQ;
                    end
                    default: begin
                        if (fetch_ack) begin
                            for (int unsigned i = 0; i < MAX_PER_LINE; i++) begin
                                if (4'(i) == fslot)
                                    slots[i].valid <= 1'b0;
                            end
                            req      <= 1'b0;
                            fetch_st <= F_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign fetch_req     = req;
    assign obj_tile_addr = size16 ? {tile[7:1], frow} : {tile, frow[2:0]};
    assign obj_attr      = attr;
    assign obj_slot      = fslot;
    assign scan_done     = done_r;
    assign obj_overflow  = overflow;
    assign obj_hits      = hits;

endmodule

// File: tb/tb_oam_obj_scanner.sv
// Scoreboard bench for oam_obj_scanner: OAM RAM model, line scans and X sweeps.
module tb_oam_obj_scanner;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic        lcd_on = 1'b1;
    logic        size16 = 1'b0;
    logic        obj_en = 1'b1;
    logic        is_gbc = 1'b0;
    logic [7:0]  v_cnt = '0;
    logic [7:0]  h_cnt = '0;
    logic        scan_start = 1'b0;
    logic        fetch_win = 1'b0;
    logic        fetch_ack = 1'b0;
    logic [7:0]  oam_rd_addr;
    logic [7:0]  oam_rd_data = '0;
    logic        oam_bus_req, fetch_req, scan_done, obj_overflow;
    logic [10:0] obj_tile_addr;
    logic [7:0]  obj_attr;
    logic [3:0]  obj_slot;
    logic [4:0]  obj_hits;

    logic [7:0] oam [256];
    int errors = 0;
    int checks = 0;

    typedef struct {
        int          slot;
        int          x;
        logic [10:0] addr;
        logic [7:0]  attr;
    } exp_t;
    exp_t exp_q[$];
    int   exp_hits;
    bit   exp_ovf;

    oam_obj_scanner #(.OBJ_COUNT(40), .MAX_PER_LINE(10), .IDX_W(6)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .ce            (ce),
        .lcd_on        (lcd_on),
        .size16        (size16),
        .obj_en        (obj_en),
        .is_gbc        (is_gbc),
        .v_cnt         (v_cnt),
        .h_cnt         (h_cnt),
        .scan_start    (scan_start),
        .fetch_win     (fetch_win),
        .oam_rd_addr   (oam_rd_addr),
        .oam_rd_data   (oam_rd_data),
        .oam_bus_req   (oam_bus_req),
        .fetch_req     (fetch_req),
        .fetch_ack     (fetch_ack),
        .obj_tile_addr (obj_tile_addr),
        .obj_attr      (obj_attr),
        .obj_slot      (obj_slot),
        .scan_done     (scan_done),
        .obj_overflow  (obj_overflow),
        .obj_hits      (obj_hits)
    );

    always #5 clk = ~clk;

    // ce is high on every other rising edge
    initial forever begin
        @(posedge clk);
        #1 ce = ~ce;
    end

    always @(posedge clk) if (ce) oam_rd_data <= oam[oam_rd_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        do @(posedge clk); while (ce !== 1'b1);
        #2;
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 256; i++) oam[i] = 8'h00;
    endtask

    task automatic set_obj(input int i, input int y, input int x, input int t, input int a);
        oam[i*4]   = 8'(y);
        oam[i*4+1] = 8'(x);
        oam[i*4+2] = 8'(t);
        oam[i*4+3] = 8'(a);
    endtask

    task automatic build_expect();
        int          n;
        int          s_idx [10];
        int          s_x [10];
        logic [3:0]  s_row [10];
        int          line;
        int          height;
        logic [7:0]  t;
        logic [7:0]  a;
        logic [3:0]  r;
        exp_t        e;
        exp_q.delete();
        exp_ovf = 1'b0;
        n = 0;
        line = int'(v_cnt) + 16;
        height = size16 ? 16 : 8;
        for (int i = 0; i < 40; i++) begin
            int y = int'(oam[i*4]);
            if (line >= y && line < y + height) begin
                if (n < 10) begin
                    s_idx[n] = i;
                    s_x[n]   = int'(oam[i*4+1]);
                    s_row[n] = 4'(line - y);
                    n++;
                end else begin
                    exp_ovf = 1'b1;
                end
            end
        end
        exp_hits = n;
        for (int hx = 0; hx < 256; hx++) begin
            for (int s = 0; s < n; s++) begin
                if (s_x[s] == hx) begin
                    t = oam[s_idx[s]*4+2];
                    a = oam[s_idx[s]*4+3];
                    r = a[6] ? ~s_row[s] : s_row[s];
                    e.slot = s;
                    e.x    = hx;
                    e.addr = size16 ? {t[7:1], r} : {t, r[2:0]};
                    e.attr = a;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic run_scan(input string tag);
        build_expect();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check_eq({tag, "_addr_y0"}, 32'(oam_rd_addr), 32'h00);
        check_eq({tag, "_bus_req"}, 32'(oam_bus_req), 32'h1);
        check_eq({tag, "_hits_clr"}, 32'(obj_hits), 32'h0);
        tick();
        check_eq({tag, "_addr_x0"}, 32'(oam_rd_addr), 32'h01);
        repeat (79) tick();
        check_eq({tag, "_done_early"}, 32'(scan_done), 32'h0);
        tick();
        check_eq({tag, "_done_81"}, 32'(scan_done), 32'h1);
        check_eq({tag, "_bus_idle"}, 32'(oam_bus_req), 32'h0);
        check_eq({tag, "_hits"}, 32'(obj_hits), 32'(exp_hits));
        check_eq({tag, "_ovf"}, 32'(obj_overflow), 32'(exp_ovf));
    endtask

    task automatic run_fetch(input int ack_delay);
        int   lat;
        int   guard;
        bit   after_ack;
        exp_t e;
        fetch_win = 1'b1;
        for (int hx = 0; hx < 256; hx++) begin
            h_cnt = 8'(hx);
            lat = 0;
            guard = 0;
            after_ack = 1'b0;
            while (guard < 12) begin
                while (!fetch_req && lat < 6) begin
                    tick();
                    lat++;
                end
                if (!fetch_req) break;
                guard++;
                if (exp_q.size() == 0 || exp_q[0].x != hx) begin
                    check_eq($sformatf("spurious_req_h%0d", hx), 32'(fetch_req), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("req_lat_h%0d", hx), 32'(lat), after_ack ? 32'd4 : 32'd3);
                    check_eq($sformatf("slot_h%0d", hx), 32'(obj_slot), 32'(e.slot));
                    check_eq($sformatf("tile_addr_h%0d", hx), 32'(obj_tile_addr), 32'(e.addr));
                    check_eq($sformatf("attr_h%0d", hx), 32'(obj_attr), 32'(e.attr));
                end
                repeat (ack_delay) tick();
                if (ack_delay > 0) check_eq("req_hold", 32'(fetch_req), 32'h1);
                fetch_ack = 1'b1;
                tick();
                fetch_ack = 1'b0;
                check_eq("req_drop", 32'(fetch_req), 32'h0);
                lat = 1;
                after_ack = 1'b1;
            end
        end
        fetch_win = 1'b0;
        h_cnt = '0;
        check_eq("fetch_left", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        clear_oam();
        tick();
        tick();
        check_eq("rst_addr", 32'(oam_rd_addr), 32'h0);
        check_eq("rst_bus", 32'(oam_bus_req), 32'h0);
        check_eq("rst_req", 32'(fetch_req), 32'h0);
        check_eq("rst_tile", 32'(obj_tile_addr), 32'h0);
        check_eq("rst_attr", 32'(obj_attr), 32'h0);
        check_eq("rst_slot", 32'(obj_slot), 32'h0);
        check_eq("rst_done", 32'(scan_done), 32'h0);
        check_eq("rst_ovf", 32'(obj_overflow), 32'h0);
        check_eq("rst_hits", 32'(obj_hits), 32'h0);
        reset_n = 1'b1;
        tick();

        // three objects incl. X=255 and the last OAM index
        v_cnt = 8'd50;
        clear_oam();
        set_obj(0, 66, 8, 8'h10, 8'h00);
        set_obj(5, 66, 20, 8'h11, 8'h20);
        set_obj(39, 66, 255, 8'h12, 8'h45);
        run_scan("three");
        check_eq("three_hits_const", 32'(obj_hits), 32'd3);
        fetch_ack = 1'b1;
        tick();
        fetch_ack = 1'b0;
        check_eq("stray_ack", 32'(fetch_req), 32'h0);
        run_fetch(1);

        // overflow: 12 hits, varying rows and flips
        v_cnt = 8'd80;
        clear_oam();
        for (int i = 0; i < 12; i++)
            set_obj(i, 96 - (i % 8), 100 + i, 8'h20 + i, (i % 2 == 1) ? 8'h40 : 8'h00);
        run_scan("ovf");
        check_eq("ovf_flag_const", 32'(obj_overflow), 32'h1);
        check_eq("ovf_hits_const", 32'(obj_hits), 32'd10);
        run_fetch(1);

        // two objects sharing X=40, slow ack
        v_cnt = 8'd60;
        clear_oam();
        set_obj(2, 76, 40, 8'h30, 8'h01);
        set_obj(9, 76, 40, 8'h31, 8'h02);
        run_scan("same_x");
        run_fetch(5);

        // 8x16: flipped offset 3, offset 15 hit, offsets 16 and -1 miss
        size16 = 1'b1;
        v_cnt = 8'd100;
        clear_oam();
        set_obj(4, 113, 30, 8'h43, 8'h40);
        set_obj(7, 101, 31, 8'h55, 8'h00);
        set_obj(8, 100, 32, 8'h56, 8'h00);
        set_obj(9, 117, 33, 8'h57, 8'h00);
        run_scan("tall");
        run_fetch(1);

        // 8x8: offset 3, flipped offset 7 hit, offsets 8 and -1 miss, X=0
        size16 = 1'b0;
        clear_oam();
        set_obj(4, 113, 30, 8'h43, 8'h00);
        set_obj(7, 109, 31, 8'h60, 8'h40);
        set_obj(8, 108, 32, 8'h61, 8'h00);
        set_obj(9, 117, 33, 8'h62, 8'h00);
        set_obj(10, 116, 0, 8'h63, 8'h10);
        run_scan("short");
        obj_en = 1'b0;
        fetch_win = 1'b1;
        h_cnt = 8'd30;
        repeat (6) tick();
        check_eq("obj_en_gate", 32'(fetch_req), 32'h0);
        fetch_win = 1'b0;
        h_cnt = 8'd0;
        is_gbc = 1'b1;
        run_fetch(1);
        is_gbc = 1'b0;
        obj_en = 1'b1;

        // restart mid-scan, LCD off, first-line skip, reset mid-fetch
        v_cnt = 8'd50;
        clear_oam();
        set_obj(0, 66, 8, 8'h10, 8'h00);
        set_obj(5, 66, 20, 8'h11, 8'h20);
        set_obj(39, 66, 255, 8'h12, 8'h45);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (30) tick();
        run_scan("restart");
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        repeat (20) tick();
        lcd_on = 1'b0;
        tick();
        check_eq("lcd_off_hits", 32'(obj_hits), 32'h0);
        check_eq("lcd_off_bus", 32'(oam_bus_req), 32'h0);
        check_eq("lcd_off_addr", 32'(oam_rd_addr), 32'h0);
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        tick();
        check_eq("lcd_off_start", 32'(oam_bus_req), 32'h0);
        lcd_on = 1'b1;
        tick();
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        check_eq("first_line_bus", 32'(oam_bus_req), 32'h0);
        repeat (81) tick();
        check_eq("first_line_done", 32'(scan_done), 32'h0);
        run_scan("after_lcd");
        fetch_win = 1'b1;
        h_cnt = 8'd20;
        for (int i = 0; i < 8 && !fetch_req; i++) tick();
        check_eq("pre_rst_req", 32'(fetch_req), 32'h1);
        check_eq("pre_rst_slot", 32'(obj_slot), 32'h1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("async_rst_req", 32'(fetch_req), 32'h0);
        check_eq("async_rst_hits", 32'(obj_hits), 32'h0);
        check_eq("async_rst_tile", 32'(obj_tile_addr), 32'h0);
        check_eq("async_rst_attr", 32'(obj_attr), 32'h0);
        check_eq("async_rst_slot", 32'(obj_slot), 32'h0);
        check_eq("async_rst_done", 32'(scan_done), 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        check_eq("post_rst_no_req", 32'(fetch_req), 32'h0);
        fetch_win = 1'b0;
        exp_q.delete();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_obj_scanner.md
# oam_obj_scanner

Parametrised successor to the per-line sprite evaluator and fetcher in the PPU object path. Scans OAM once per line through an external single-read-port OAM RAM and stores up to `MAX_PER_LINE` hits. During pixel transfer it hands each object's tile address and attributes to the PPU fetcher, in X-match order.

New over the previous generation:
- configurable object and slot counts;
- per-slot valid bits, so X = 0xFF objects are fetchable;
- a sticky overflow flag;
- an explicit request/acknowledge fetch handshake;
- asynchronous reset.

## Interface
Parameters:
- `OBJ_COUNT`, 40: OAM entries scanned (1..64).
- `MAX_PER_LINE`, 10: slot depth (1..16).
- `IDX_W`, 6: object index width; must satisfy `OBJ_COUNT <= 2**IDX_W`.

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `ce` in 1: PPU clock enable; all state advances only when `ce`=1.
- `lcd_on` in 1: LCD enable; low forces idle.
- `size16` in 1: 8x16 object mode.
- `obj_en` in 1: LCDC object enable.
- `is_gbc` in 1: GBC mode; fetches proceed even with `obj_en`=0.
- `v_cnt` in 8: current line.
- `h_cnt` in 8: current fetcher X.
- `scan_start` in 1: one-`ce` pulse at line start (mode 2 entry).
- `fetch_win` in 1: high during mode 3.
- `oam_rd_addr` out 8: OAM read address.
- `oam_rd_data` in 8: OAM data for the address presented on the previous `ce`.
- `oam_bus_req` out 1: block owns the OAM read port this `ce`.
- `fetch_req` out 1: object ready for the fetcher.
- `fetch_ack` in 1: fetcher consumed the object.
- `obj_tile_addr` out 11: tile-row address (`size16`: {tile[7:1],row}; else {tile,row[2:0]}).
- `obj_attr` out 8: attribute byte.
- `obj_slot` out 4: slot index being fetched.
- `scan_done` out 1: scan finished for this line.
- `obj_overflow` out 1: more than `MAX_PER_LINE` objects hit this line.
- `obj_hits` out 5: number of slots filled.

## Operation
Reset values: all outputs 0, all slots invalid, both FSMs idle.

Scan FSM, states `S_IDLE`, `S_Y`, `S_X`, `S_DONE`:
- `scan_start` loads `S_Y` with idx=0.
- `S_Y`: drive addr {idx,00}.
- `S_X`: drive addr {idx,01}; `oam_rd_data` is Y. Latch Y.
- Next `S_Y` (or `S_DONE`): `oam_rd_data` is X. Commit the hit if `v_cnt+16 >= Y` and `v_cnt+16 < Y+height`, computed in 9-bit arithmetic, with height 8 or 16.
  - The commit writes index, X, `row = (v_cnt+16-Y)[3:0]`, and valid into the next free slot, then increments `obj_hits`.
  - A hit arriving with all slots full sets `obj_overflow` and is dropped.
- idx increments after each `S_X`. After the last `S_X` at idx `OBJ_COUNT-1`, one commit cycle runs, then `S_DONE`.
- `S_DONE` asserts `scan_done`, which holds until the next `scan_start`.
- `scan_start` in any state clears all slots, `obj_hits`, `obj_overflow` and `scan_done`, then restarts at idx 0. A fetch in progress is aborted.
- `lcd_on`=0: both FSMs are held in IDLE, slots are cleared, and outputs are at reset values.
- While `lcd_on`=0 the next `scan_start` is ignored; the first line after enable performs no scan.

Fetch FSM, states `F_IDLE`, `F_TILE`, `F_ATTR`, `F_REQ`:
- `F_IDLE`: leaves when `fetch_win`, (`obj_en` or `is_gbc`) and any valid slot has X == `h_cnt`. The lowest-numbered matching slot is latched as `obj_slot`. Next state `F_TILE`, drive {idx,10}.
- `F_TILE`: drive {idx,11}; latch tile.
- `F_ATTR`: latch attr; row = attr[6] ? ~row : row.
- `F_REQ`: assert `fetch_req`. On `fetch_ack`, clear the slot's valid bit and return to `F_IDLE`.

OAM port arbitration:
- `oam_bus_req` is high in `S_Y`, `S_X` and `F_TILE`/`F_ATTR` address phases.
- Scan and fetch never overlap, because `fetch_win` and scan are mutually exclusive by PPU construction.
- If both are requested, scan wins and fetch stalls in `F_IDLE`.

## Timing
- Scan: 2·`OBJ_COUNT`+1 `ce` cycles; 81 at defaults. `scan_done` rises on `ce` 81 after `scan_start`.
- Fetch: match to `fetch_req` is 3 `ce`. `fetch_req` is registered and stays high until `fetch_ack`.
- Ack-to-next-`fetch_req` for a second object at the same X: 4 `ce`. The slot clears on the ack `ce`, and `F_IDLE` re-evaluates the next `ce`.
- `fetch_ack` outside `F_REQ` is ignored.
- `reset_n` low mid-scan or mid-fetch returns immediately to reset values, with no partial slot writes.

## Structure
- Package `gb_obj_pkg` holds:
  - OAM byte offsets (Y=0, X=1, TILE=2, ATTR=3);
  - scan-state and fetch-state enums;
  - the `obj_slot_t` record {valid, idx, x, row}.
- Sub-module `obj_slot_select` is a combinational priority encoder over (valid & x==`h_cnt`). It outputs `any` and the lowest slot number.

## Test plan
- Objects 0, 5 and 39 at Y=v_cnt+16, X=8/20/255 → `obj_hits`=3, `scan_done` at `ce` 81. `fetch_req` appears at `h_cnt`=8, 20 and 255 with slots 0/1/2.
- 12 objects on the line → slots hold indices 0..9, `obj_overflow`=1, `obj_hits`=10.
- Two objects at the same X=40, with the ack delayed 5 `ce` → two sequential requests, the lower slot first, 4 `ce` apart after the ack.
- `size16`=1, tile=0x43, attr=0x40, line offset 3 → `obj_tile_addr`={0x21,4'hC}.
- `size16`=0, tile=0x43, attr=0x00, offset 3 → `obj_tile_addr`=0x21B.
- Sequence `scan_start` mid-scan, then `lcd_on` dropped, then `reset_n` pulsed mid-fetch → restart at idx 0, clear state, and outputs return to 0 respectively.
